// File: rtl/uninasoc_pkg.sv
// Shared SoC constants: GPIO input width, crossbar slave count, register offsets, FSM states.
package uninasoc_pkg;

  localparam int unsigned NUM_GPIO_IN        = 8;
  localparam int unsigned NUM_AXI_AXI_SLAVES = 1;

  localparam logic [3:0] GPIO_IN_DATA_OFF       = 4'h0;
  localparam logic [3:0] GPIO_IN_IRQ_EN_OFF     = 4'h4;
  localparam logic [3:0] GPIO_IN_EDGE_SEL_OFF   = 4'h8;
  localparam logic [3:0] GPIO_IN_IRQ_STATUS_OFF = 4'hC;

  typedef enum logic [0:0] {W_IDLE, W_RESP} w_state_e;
  typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_e;

endpackage

// File: rtl/axilite_gpio_in_if.sv
// AXI4-Lite bus bundle for the GPIO input block.
interface axilite_gpio_in_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  awvalid, awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  wvalid, wready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  bvalid, bready;
  logic [1:0]            bresp;
  logic                  arvalid, arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  rvalid, rready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/gpio_in_sync.sv
// Two-flop synchronizer for asynchronous GPIO inputs.
module gpio_in_sync #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);
  logic [WIDTH-1:0] meta_q, sync_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;
endmodule

// File: rtl/axilite_gpio_in.sv
// AXI4-Lite GPIO input peripheral: synchronized pin read-back and edge-triggered interrupts.
module axilite_gpio_in
  import uninasoc_pkg::*;
#(
  parameter int unsigned NUM_GPIO   = NUM_GPIO_IN,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic [NUM_GPIO-1:0] gpio_i,
  axilite_gpio_in_if.slave    s_axil,
  output logic                irq_o
);
  logic [NUM_GPIO-1:0] sampled, prev_q, edge_hit, clr_mask, wmask_g, wbits_g;
  logic [NUM_GPIO-1:0] irq_en_q, irq_en_d, edge_sel_q, edge_sel_d, status_q, status_d;
  logic [1:0]          prime_q;
  logic                primed, w_accept, r_accept;
  logic [31:0]         wmask, wbits, rd_mux, rdata_q;
  logic [3:0]          waddr, raddr;
  w_state_e            w_state_q, w_state_d;
  r_state_e            r_state_q, r_state_d;

  gpio_in_sync #(.WIDTH(NUM_GPIO)) u_sync (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .async_i (gpio_i),
    .sync_o  (sampled)
  );

  assign waddr    = {s_axil.awaddr[3:2], 2'b00};
  assign raddr    = {s_axil.araddr[3:2], 2'b00};
  assign wmask    = {{8{s_axil.wstrb[3]}}, {8{s_axil.wstrb[2]}},
                     {8{s_axil.wstrb[1]}}, {8{s_axil.wstrb[0]}}};
  assign wbits    = s_axil.wdata & wmask;
  assign wmask_g  = wmask[NUM_GPIO-1:0];
  assign wbits_g  = wbits[NUM_GPIO-1:0];
  assign primed   = (prime_q == 2'd3);
  assign w_accept = (w_state_q == W_IDLE) && s_axil.awvalid && s_axil.wvalid && !reset_i;
  assign r_accept = (r_state_q == R_IDLE) && s_axil.arvalid && !reset_i;

  logic unused_bits;
  assign unused_bits = ^{s_axil.awaddr[ADDR_WIDTH-1:4], s_axil.awaddr[1:0],
                         s_axil.araddr[ADDR_WIDTH-1:4], s_axil.araddr[1:0], wbits, wmask};

  // Edge detection stays masked until the synchronizer has been flushed after reset.
  always_comb begin
    edge_hit = '0;
    if (primed) begin
      edge_hit = (sampled & ~prev_q & edge_sel_q) | (~sampled & prev_q & ~edge_sel_q);
    end
  end

  always_comb begin
    irq_en_d   = irq_en_q;
    edge_sel_d = edge_sel_q;
    clr_mask   = '0;
    if (w_accept) begin
      case (waddr)
        GPIO_IN_IRQ_EN_OFF:     irq_en_d   = (irq_en_q & ~wmask_g) | wbits_g;
        GPIO_IN_EDGE_SEL_OFF:   edge_sel_d = (edge_sel_q & ~wmask_g) | wbits_g;
        GPIO_IN_IRQ_STATUS_OFF: clr_mask   = wbits_g;
        default: ;
      endcase
    end
    // A fresh edge wins over a simultaneous clear.
    status_d = (status_q & ~clr_mask) | edge_hit;
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (w_accept) w_state_d = W_RESP;
      W_RESP:  if (s_axil.bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rd_mux    = '0;
    case (raddr)
      GPIO_IN_DATA_OFF:       rd_mux[NUM_GPIO-1:0] = sampled;
      GPIO_IN_IRQ_EN_OFF:     rd_mux[NUM_GPIO-1:0] = irq_en_q;
      GPIO_IN_EDGE_SEL_OFF:   rd_mux[NUM_GPIO-1:0] = edge_sel_q;
      GPIO_IN_IRQ_STATUS_OFF: rd_mux[NUM_GPIO-1:0] = status_q;
      default: ;
    endcase
    case (r_state_q)
      R_IDLE:  if (r_accept) r_state_d = R_DATA;
      R_DATA:  if (s_axil.rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      prev_q     <= '0;
      prime_q    <= '0;
      irq_en_q   <= '0;
      edge_sel_q <= '1;
      status_q   <= '0;
      rdata_q    <= '0;
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
    end else begin
      prev_q     <= sampled;
      if (!primed) prime_q <= prime_q + 2'd1;
      irq_en_q   <= irq_en_d;
      edge_sel_q <= edge_sel_d;
      status_q   <= status_d;
      if (r_accept) rdata_q <= rd_mux;
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
    end
  end

  assign s_axil.awready = w_accept;
  assign s_axil.wready  = w_accept;
  assign s_axil.bvalid  = (w_state_q == W_RESP);
  assign s_axil.bresp   = 2'b00;
  assign s_axil.arready = (r_state_q == R_IDLE) && !reset_i;
  assign s_axil.rvalid  = (r_state_q == R_DATA);
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = 2'b00;

  assign irq_o = |(status_q & irq_en_q);
endmodule

// File: tb/tb_axilite_gpio_in.sv
// Directed bench for axilite_gpio_in with a read-data scoreboard queue.
module tb_axilite_gpio_in;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gpio;
  logic       irq;
  int         checks = 0;
  int         errors = 0;
  logic [31:0] exp_q[$];

  localparam logic [31:0] A_DATA = 32'h0, A_EN = 32'h4, A_SEL = 32'h8, A_STAT = 32'hC;

  always #5 clk = ~clk;

  axilite_gpio_in_if #(.ADDR_WIDTH(32)) bus ();

  axilite_gpio_in #(.NUM_GPIO(8), .ADDR_WIDTH(32)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .gpio_i  (gpio),
    .s_axil  (bus),
    .irq_o   (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input string tag);
    int n;
    bus.awvalid = 1'b1; bus.awaddr = addr;
    bus.wvalid  = 1'b1; bus.wdata  = data; bus.wstrb = strb;
    #1;
    n = 0;
    while (!(bus.awready && bus.wready) && n < 20) begin step(); n++; end
    check({tag, "_awready"}, 32'(bus.awready), 32'd1);
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 20) begin step(); n++; end
    check({tag, "_bvalid"}, 32'(bus.bvalid), 32'd1);
    check({tag, "_bresp"}, 32'(bus.bresp), 32'd0);
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    int n;
    exp_q.push_back(exp);
    bus.arvalid = 1'b1; bus.araddr = addr;
    #1;
    n = 0;
    while (!bus.arready && n < 20) begin step(); n++; end
    check({tag, "_arready"}, 32'(bus.arready), 32'd1);
    step();
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 20) begin step(); n++; end
    check({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
    check(tag, bus.rdata, exp_q.pop_front());
    check({tag, "_rresp"}, 32'(bus.rresp), 32'd0);
    bus.rready = 1'b1;
    step();
    bus.rready = 1'b0;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; gpio = 8'hFF;
    bus.awvalid = 1'b1; bus.awaddr = '0; bus.wvalid = 1'b1; bus.wdata = '0; bus.wstrb = '0;
    bus.bready = 1'b0; bus.arvalid = 1'b1; bus.araddr = '0; bus.rready = 1'b0;
    step(); step();
    check("rst_awready", 32'(bus.awready), 32'd0);
    check("rst_arready", 32'(bus.arready), 32'd0);
    check("rst_bvalid", 32'(bus.bvalid), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    rst = 1'b0;
    repeat (6) step();

    // Pins high through reset release must not register as edges.
    axi_read(A_STAT, 32'h0, "prime_status");
    axi_read(A_SEL, 32'hFF, "rst_edge_sel");
    axi_read(A_EN, 32'h0, "rst_irq_en");
    axi_read(A_DATA, 32'hFF, "data_ff");

    gpio = 8'h00;
    repeat (5) step();
    gpio = 8'hA5;
    axi_read(A_DATA, 32'h00, "data_early");
    repeat (3) step();
    axi_read(32'hFFFF_FFF0, 32'hA5, "data_a5");
    axi_read(A_STAT, 32'hA5, "status_rise_a5");
    check("irq_disabled", 32'(irq), 32'd0);
    axi_write(A_STAT, 32'hFF, 4'hF, "w1c_all");
    axi_read(A_STAT, 32'h00, "status_cleared");

    gpio = 8'hA4;
    repeat (5) step();
    axi_read(A_STAT, 32'h00, "fall_unselected");
    axi_write(A_EN, 32'h01, 4'hF, "en_01");
    gpio = 8'hA5;
    repeat (5) step();
    check("irq_set", 32'(irq), 32'd1);
    axi_read(A_STAT, 32'h01, "status_bit0");
    axi_write(A_STAT, 32'h01, 4'hF, "w1c_bit0");
    check("irq_clr", 32'(irq), 32'd0);
    axi_read(A_STAT, 32'h00, "status_bit0_clr");

    axi_write(A_SEL, 32'hFE, 4'hF, "sel_fe");
    gpio = 8'hA4;
    repeat (5) step();
    axi_read(A_STAT, 32'h01, "fall_selected");
    axi_write(A_STAT, 32'h01, 4'hF, "w1c_fall");
    gpio = 8'hA5;
    repeat (5) step();
    axi_read(A_STAT, 32'h00, "rise_unselected");
    axi_read(A_SEL, 32'hFE, "sel_readback");

    axi_write(32'h1230_0004, 32'hFFFF_FFFF, 4'h0, "strb_none");
    axi_read(A_EN, 32'h01, "en_strb_none");
    axi_write(A_EN, 32'hFFFF_FFFF, 4'hF, "en_all");
    axi_read(A_EN, 32'h0000_00FF, "en_upper_zero");
    axi_write(A_EN, 32'h01, 4'hF, "en_restore");
    axi_write(A_DATA, 32'h5A, 4'hF, "data_ro");
    axi_read(A_DATA, 32'hA5, "data_unchanged");

    axi_write(A_SEL, 32'hFF, 4'hF, "sel_ff");
    gpio = 8'hA1;
    repeat (5) step();
    // Time the rise on bit 2 so its status update lands on the W1C accept edge.
    gpio = 8'hA5;
    step(); step();
    axi_write(A_STAT, 32'h04, 4'hF, "w1c_race");
    axi_read(A_STAT, 32'h04, "set_beats_clear");
    check("irq_masked", 32'(irq), 32'd0);

    exp_q.push_back(32'h04);
    bus.awvalid = 1'b1; bus.awaddr = A_STAT; bus.wvalid = 1'b1; bus.wdata = 32'h04;
    bus.wstrb = 4'hF; bus.arvalid = 1'b1; bus.araddr = A_STAT;
    #1;
    check("conc_awready", 32'(bus.awready), 32'd1);
    check("conc_arready", 32'(bus.arready), 32'd1);
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    check("conc_bvalid", 32'(bus.bvalid), 32'd1);
    check("conc_rvalid", 32'(bus.rvalid), 32'd1);
    check("conc_preclear", bus.rdata, exp_q.pop_front());
    bus.bready = 1'b1; bus.rready = 1'b1;
    step();
    bus.bready = 1'b0; bus.rready = 1'b0;
    axi_read(A_STAT, 32'h00, "conc_postclear");

    bus.awvalid = 1'b1; bus.awaddr = A_EN; bus.wdata = 32'h02; bus.wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("wait_w_awready", 32'(bus.awready), 32'd0);
      step();
    end
    bus.wvalid = 1'b1;
    #1;
    check("late_w_awready", 32'(bus.awready), 32'd1);
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("hold_bvalid", 32'(bus.bvalid), 32'd1);
      check("hold_bresp", 32'(bus.bresp), 32'd0);
      step();
    end
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    check("bvalid_drop", 32'(bus.bvalid), 32'd0);
    axi_read(A_EN, 32'h02, "en_late_w");

    bus.awvalid = 1'b1; bus.awaddr = A_SEL; bus.wvalid = 1'b1; bus.wdata = 32'h0F;
    #1;
    check("abort_awready", 32'(bus.awready), 32'd1);
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("abort_bvalid_pre", 32'(bus.bvalid), 32'd1);
    rst = 1'b1;
    step();
    check("abort_bvalid", 32'(bus.bvalid), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("abort_no_resp", 32'(bus.bvalid), 32'd0);
      step();
    end
    repeat (4) step();
    axi_read(A_SEL, 32'hFF, "post_rst_sel");
    axi_read(A_EN, 32'h00, "post_rst_en");
    axi_read(A_STAT, 32'h00, "post_rst_status");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
